// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry constants and fill-controller state type.
//   ADDR_W      byte-address width
//   WORDS       16-bit words per block (power of two)
//   BLOCK_BYTES block size in bytes
//   OFFSET_W    byte-offset width within a block
package cache_pkg;
    localparam int ADDR_W = 16;
    localparam int WORDS = 8;
    localparam int BLOCK_BYTES = 2 * WORDS;
    localparam int OFFSET_W = $clog2(BLOCK_BYTES);
    typedef enum logic {IDLE, FILL} fill_state_t;
endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss, memory-arbiter and cache-array signals of a fill controller.
//   master: the fill controller (consumes miss/memory inputs, drives requests and array writes)
//   slave:  the surrounding cache, arbiter and memory
interface cache_fill_fsm_if #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int WORDS = cache_pkg::WORDS
);
    logic miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic mem_grant;
    logic memory_data_valid;
    logic [15:0] memory_data;
    logic fsm_busy;
    logic memory_read;
    logic [ADDR_W-1:0] memory_address;
    logic write_data_array;
    logic [$clog2(WORDS)-1:0] fill_word;
    logic [15:0] fill_data;
    logic write_tag_array;
    logic [ADDR_W-1:0] fill_base;

    modport master (
        input miss_detected, miss_address, mem_grant, memory_data_valid, memory_data,
        output fsm_busy, memory_read, memory_address, write_data_array, fill_word,
        output fill_data, write_tag_array, fill_base
    );
    modport slave (
        output miss_detected, miss_address, mem_grant, memory_data_valid, memory_data,
        input fsm_busy, memory_read, memory_address, write_data_array, fill_word,
        input fill_data, write_tag_array, fill_base
    );
endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// fill_counter: saturating 0..MAX counter with synchronous clear and increment enable.
//   clk, rst  clock and synchronous active-high reset
//   clr       synchronous clear to 0
//   inc       increment (ignored once MAX is reached)
//   cnt       current count
module fill_counter #(
    parameter int MAX = 8,
    parameter int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc && cnt < W'(MAX)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss handler fetching one block as WORDS 16-bit words.
//   clk, rst  clock and synchronous active-high reset
//   bus       master side of cache_fill_fsm_if: miss input, memory request/response,
//             data/tag array writes, busy stall and current fill base
module cache_fill_fsm #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int WORDS = cache_pkg::WORDS
) (
    input logic clk,
    input logic rst,
    cache_fill_fsm_if.master bus
);
    import cache_pkg::*;

    localparam int CW = $clog2(WORDS) + 1;
    localparam int WW = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(2 * WORDS - 1);

    fill_state_t state;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0] reqCnt, rspCnt;
    logic inFill, startFill, reqFire, rspFire, lastRsp;

    always_comb begin
        inFill = state == FILL;
        startFill = !inFill && bus.miss_detected;
        bus.memory_read = inFill && reqCnt < CW'(WORDS);
        reqFire = bus.memory_read && bus.mem_grant;
        // only responses matching an outstanding request are taken; the rest are dropped
        rspFire = inFill && bus.memory_data_valid && rspCnt < reqCnt;
        lastRsp = rspFire && rspCnt == CW'(WORDS - 1);
        // stall starts combinationally in the miss cycle itself
        bus.fsm_busy = inFill || bus.miss_detected;
        bus.memory_address = base + (ADDR_W'(reqCnt) << 1);
        bus.write_data_array = rspFire;
        bus.fill_word = rspCnt[WW-1:0];
        bus.fill_data = bus.memory_data;
        bus.write_tag_array = lastRsp;
        bus.fill_base = base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base <= '0;
        end else if (startFill) begin
            state <= FILL;
            base <= bus.miss_address & ~OFFSET_MASK;
        end else if (lastRsp) begin
            state <= IDLE;
        end
    end

    fill_counter #(.MAX(WORDS), .W(CW)) reqCounter (
        .clk(clk), .rst(rst), .clr(startFill), .inc(reqFire), .cnt(reqCnt)
    );

    fill_counter #(.MAX(WORDS), .W(CW)) rspCounter (
        .clk(clk), .rst(rst), .clr(startFill), .inc(rspFire), .cnt(rspCnt)
    );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed checks of cache_fill_fsm against a 4-cycle-latency memory model.
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic miss = 1'b0;
    logic [15:0] missAddr = '0;
    logic grant = 1'b0;
    logic inj = 1'b0;
    logic [15:0] injData = '0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int due;
        logic [15:0] addr;
    } req_t;
    req_t q[$];

    cache_fill_fsm_if bus();

    cache_fill_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one cycle: apply inputs mid-cycle, let the memory model answer, then record granted requests
    task automatic step;
        @(negedge clk);
        cyc++;
        bus.miss_detected = miss;
        bus.miss_address = missAddr;
        bus.mem_grant = grant;
        if (q.size() > 0 && q[0].due == cyc) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data = mdata(q[0].addr);
            void'(q.pop_front());
        end else begin
            bus.memory_data_valid = inj;
            bus.memory_data = injData;
        end
        #1;
        if (bus.memory_read && bus.mem_grant) q.push_back('{cyc + 4, bus.memory_address});
    endtask

    task automatic runFill(input logic [15:0] addr, input logic [15:0] blk, input string tag);
        miss = 1'b1;
        missAddr = addr;
        grant = 1'b1;
        step;
        check({tag, " busy miss cycle"}, bus.fsm_busy, 1);
        miss = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step;
            check($sformatf("%s k%0d read", tag, k), bus.memory_read, k <= 8);
            if (k <= 8) check($sformatf("%s k%0d addr", tag, k), bus.memory_address, blk + 16'(2 * (k - 1)));
            check($sformatf("%s k%0d wda", tag, k), bus.write_data_array, k >= 5 && k <= 12);
            if (k >= 5 && k <= 12) begin
                check($sformatf("%s k%0d word", tag, k), bus.fill_word, k - 5);
                check($sformatf("%s k%0d data", tag, k), bus.fill_data, mdata(blk + 16'(2 * (k - 5))));
            end
            check($sformatf("%s k%0d wta", tag, k), bus.write_tag_array, k == 12);
            check($sformatf("%s k%0d busy", tag, k), bus.fsm_busy, k <= 12);
            if (k <= 12) check($sformatf("%s k%0d base", tag, k), bus.fill_base, blk);
        end
    endtask

    initial begin
        bus.miss_detected = 1'b0;
        bus.miss_address = '0;
        bus.mem_grant = 1'b0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data = '0;
        step;
        step;
        rst = 1'b0;
        step;
        check("rst busy", bus.fsm_busy, 0);
        check("rst read", bus.memory_read, 0);
        check("rst wda", bus.write_data_array, 0);
        check("rst wta", bus.write_tag_array, 0);
        check("rst addr", bus.memory_address, 0);
        check("rst base", bus.fill_base, 0);

        runFill(16'h1236, 16'h1230, "basic");

        // grant withheld on two fill cycles: address 0x1234 held, tag write two cycles later
        miss = 1'b1;
        missAddr = 16'h1236;
        grant = 1'b1;
        step;
        miss = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            int w;
            logic expW;
            grant = !(k == 3 || k == 4);
            step;
            expW = k == 5 || k == 6 || (k >= 9 && k <= 14);
            w = k <= 6 ? k - 5 : k - 7;
            check($sformatf("stall k%0d read", k), bus.memory_read, k <= 10);
            if (k >= 3 && k <= 5) check($sformatf("stall k%0d addr", k), bus.memory_address, 16'h1234);
            check($sformatf("stall k%0d wda", k), bus.write_data_array, expW);
            if (expW) begin
                check($sformatf("stall k%0d word", k), bus.fill_word, w);
                check($sformatf("stall k%0d data", k), bus.fill_data, mdata(16'h1230 + 16'(2 * w)));
            end
            check($sformatf("stall k%0d wta", k), bus.write_tag_array, k == 14);
            check($sformatf("stall k%0d busy", k), bus.fsm_busy, k <= 14);
        end
        grant = 1'b1;

        // reset in the cycle rsp_cnt reaches 3; later responses must be dropped
        miss = 1'b1;
        missAddr = 16'h0400;
        step;
        miss = 1'b0;
        for (int k = 1; k <= 7; k++) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        for (int k = 9; k <= 14; k++) begin
            step;
            check($sformatf("mrst k%0d busy", k), bus.fsm_busy, 0);
            check($sformatf("mrst k%0d read", k), bus.memory_read, 0);
            check($sformatf("mrst k%0d wda", k), bus.write_data_array, 0);
            check($sformatf("mrst k%0d wta", k), bus.write_tag_array, 0);
            if (k == 9) check("mrst base", bus.fill_base, 0);
        end

        // miss held through a fill with another address: back-to-back fills
        missAddr = 16'h2002;
        miss = 1'b1;
        step;
        missAddr = 16'h3008;
        for (int k = 1; k <= 26; k++) begin
            miss = k <= 13;
            step;
            check($sformatf("b2b k%0d busy", k), bus.fsm_busy, k <= 25);
            if (k <= 25) check($sformatf("b2b k%0d base", k), bus.fill_base, k <= 13 ? 16'h2000 : 16'h3000);
            check($sformatf("b2b k%0d read", k), bus.memory_read, k <= 8 || (k >= 14 && k <= 21));
            if (k <= 8) check($sformatf("b2b k%0d addr", k), bus.memory_address, 16'h2000 + 16'(2 * (k - 1)));
            if (k >= 14 && k <= 21) check($sformatf("b2b k%0d addr", k), bus.memory_address, 16'h3000 + 16'(2 * (k - 14)));
            check($sformatf("b2b k%0d wda", k), bus.write_data_array, (k >= 5 && k <= 12) || (k >= 18 && k <= 25));
            check($sformatf("b2b k%0d wta", k), bus.write_tag_array, k == 12 || k == 25);
        end
        miss = 1'b0;

        runFill(16'hFFFA, 16'hFFF0, "wrap");

        // spurious valid with nothing outstanding
        miss = 1'b1;
        missAddr = 16'h0100;
        grant = 1'b0;
        step;
        miss = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            grant = k >= 3;
            inj = k <= 2;
            injData = 16'hDEAD;
            step;
            if (k <= 3) begin
                check($sformatf("spur k%0d read", k), bus.memory_read, 1);
                check($sformatf("spur k%0d addr", k), bus.memory_address, 16'h0100);
                check($sformatf("spur k%0d wda", k), bus.write_data_array, 0);
            end
            if (k == 7) begin
                check("spur k7 wda", bus.write_data_array, 1);
                check("spur k7 word", bus.fill_word, 0);
                check("spur k7 data", bus.fill_data, mdata(16'h0100));
            end
            check($sformatf("spur k%0d wta", k), bus.write_tag_array, k == 14);
            check($sformatf("spur k%0d busy", k), bus.fsm_busy, k <= 14);
        end
        inj = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller shared in form by the I-cache and D-cache of the pipelined CPU; one instance per cache. On a cache miss it stalls the pipeline and fetches the 16-byte block from the multi-cycle main memory as eight 16-bit words. It writes each returned word into the data array, then writes the tag array on the final word. It sits between the cache tag/data arrays (downstream consumer of its writes) and the memory arbiter (upstream supplier of grants and data). Its `fsm_busy`, `write_tag_array` and miss interplay are the signals the pipeline stall logic and the stats instrumentation observe.

## Interface
Parameters:
- `ADDR_W`, 16, byte-address width.
- `WORDS`, 8, 16-bit words per block. Must be a power of two; block size in bytes is 2*`WORDS`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `miss_detected`  in  1  cache lookup missed this cycle.
- `miss_address`  in  `ADDR_W`  byte address of the missing access.
- `mem_grant`  in  1  arbiter accepts this cycle's `memory_read` request.
- `memory_data_valid`  in  1  `memory_data` holds the next in-order response word.
- `memory_data`  in  16  response word.
- `fsm_busy`  out  1  fill in progress; pipeline stalls.
- `memory_read`  out  1  request valid.
- `memory_address`  out  `ADDR_W`  request byte address.
- `write_data_array`  out  1  write `fill_data` to data array word `fill_word` of the block.
- `fill_word`  out  log2(`WORDS`)  word index within the block.
- `fill_data`  out  16  equals `memory_data`.
- `write_tag_array`  out  1  write tag and set valid for block `base`.
- `fill_base`  out  `ADDR_W`  block-aligned base of the current fill.

## Operation
- States: IDLE, FILL.
- Registers: `base`, `req_cnt` and `rsp_cnt`, each 0..`WORDS`.

IDLE:
- `fsm_busy` = `miss_detected`. This is combinational, so the stall starts in the miss cycle.
- On `miss_detected`: `base` <= `miss_address` with its low log2(2*`WORDS`) bits cleared. Clear both counters. Go to FILL.

FILL:
- `fsm_busy` = 1.
- `memory_read` = (`req_cnt` < `WORDS`).
- `memory_address` = `base` + 2*`req_cnt`, truncated to `ADDR_W`.
- `req_cnt` increments when `memory_read` & `mem_grant`. If the request is not granted, `memory_read` and `memory_address` are held unchanged.
- A response is accepted when `memory_data_valid` & (`rsp_cnt` < `req_cnt`). Responses with no outstanding request are ignored.
- On each accepted response: `write_data_array` = 1, `fill_word` = `rsp_cnt`, and `rsp_cnt` increments.
- On the accepted response with `rsp_cnt` = `WORDS`-1: `write_tag_array` = 1 in the same cycle, and the next state is IDLE.

Everywhere:
- `miss_detected` is ignored while in FILL.
- `memory_data_valid` is ignored in IDLE, so late responses after a reset are dropped.
- `fill_base` = `base` in all states.

## Timing
- Reset values: state IDLE, counters 0, `base` 0.
- Outputs after reset: `fsm_busy`, `memory_read`, `write_data_array` and `write_tag_array` are 0 (`fsm_busy` follows `miss_detected` in IDLE). `memory_address` and `fill_base` are 0.
- `rst` asserted mid-fill: IDLE on the next edge. No tag write occurs. The partially filled block stays invalid.
- Miss in cycle N: first request in N+1. With a 4-cycle memory latency and continuous grant, the first `write_data_array` is at N+5. The last response and `write_tag_array` are at N+12. `fsm_busy` is high from N through N+12 and low at N+13.
- The block adds no latency beyond that. Requests and responses overlap fully, with one request per cycle at most.
- A miss presented in the cycle `fsm_busy` deasserts (back in IDLE) starts a new fill immediately.
- Address wrap: `base` + 2*`req_cnt` wraps modulo 2^`ADDR_W`. Blocks are aligned, so no wrap occurs within a block except at the top block, which is `0xFFF0` to `0xFFFE`.

## Structure
- Shared package `cache_pkg` holds:
  - `ADDR_W`, `WORDS`, the block byte size, and the offset width.
  - the `fill_state_t` enum {IDLE, FILL}.
- Natural sub-module: `fill_counter`, a saturating 0..`WORDS` counter with synchronous clear and increment-enable. It is instantiated twice, once for `req_cnt` and once for `rsp_cnt`.
- All outputs except the registered state and counters are combinational decodes.

## Test plan
- Miss at `0x1236`, grant always, 4-cycle memory:
  - requests go to `0x1230`, `0x1232`, …, `0x123E` in N+1..N+8.
  - `write_data_array` fires with `fill_word` 0..7 in N+5..N+12.
  - `write_tag_array` fires at N+12; `fsm_busy` falls at N+13.
- Grant withheld on cycles 2 and 3 of the fill:
  - `memory_address` holds `0x1234` across the stall.
  - All 8 words are still written in order.
  - The tag write is delayed by 2 cycles.
- `rst` pulsed while `rsp_cnt` = 3:
  - IDLE on the next cycle, with no `write_tag_array`.
  - Subsequent `memory_data_valid` pulses produce no `write_data_array`.
- `miss_detected` held high throughout the fill, with a different address:
  - `base` is unchanged.
  - After the tag write, a new fill starts at the new block with no idle gap.
- Miss at `0xFFFA`:
  - addresses are `0xFFF0` to `0xFFFE`.
  - `fill_base` is `0xFFF0`.
- Spurious `memory_data_valid` while `rsp_cnt` = `req_cnt`: ignored, with no write and no counter change.
